// File: rtl/fp16_row_accumulator.sv
// -----------------------------------------------------------------------------
// fp16_row_accumulator
//
// Sums a stream of FP16 products into one FP16 row total for a sparse
// matrix-vector engine. Each accepted product walks through a small
// ALIGN -> ADD -> NORM pipeline, one stage per enabled cycle. Only one product
// is in flight at a time. The product flagged as the last of its row parks
// the FSM in OUT until downstream takes the result.
// Arithmetic is truncating. Denormal inputs are treated as signed zeros, and
// results below the normal range are flushed to +0.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   clk_en            global enable; when low, every register holds
//   in_valid/in_ready product handshake (ready only in IDLE)
//   in_data, in_last  FP16 product and end-of-row marker
//   out_valid/out_ready row-sum handshake (valid only in OUT)
//   out_data          FP16 row sum (the accumulator itself)
//   out_count         products accumulated this row, saturating
//   out_overflow, out_underflow, out_nan   sticky row flags
//   out_zero          high when out_data is +0
// -----------------------------------------------------------------------------
module fp16_row_accumulator #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_nan,
  output logic             out_zero
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

  state_t state;

  // Running row sum. It is also the output register.
  logic [15:0] acc;

  // Operand captured at accept
  logic [15:0] prod_q;
  logic        last_q;

  // ALIGN stage results
  logic        al_sign;
  logic        al_sub;
  logic [4:0]  al_exp;
  logic [13:0] al_big;
  logic [13:0] al_small;
  logic        spc_q;
  logic        spc_nan_q;
  logic [15:0] spc_data_q;

  // ADD stage results: carry, hidden bit, 10 mantissa bits, G, R, S
  logic [14:0] sum_q;
  logic        sum_sign;
  logic [4:0]  sum_exp;

  assign out_data = acc;

  // ---------------------------------------------------------------------------
  // Operand classification for the accumulator (a) and the captured
  // product (b). Exponent 0 collapses to a signed zero. Exponent 31 is
  // either an infinity or a NaN.
  // ---------------------------------------------------------------------------
  logic        a_sign, b_sign;
  logic        a_zero, b_zero;
  logic        a_inf, b_inf, a_nan, b_nan;
  logic [14:0] a_key, b_key;

  assign a_sign = acc[15];
  assign b_sign = prod_q[15];
  assign a_zero = (acc[14:10] == 5'd0);
  assign b_zero = (prod_q[14:10] == 5'd0);
  assign a_inf  = (acc[14:10] == 5'h1F) && (acc[9:0] == 10'd0);
  assign b_inf  = (prod_q[14:10] == 5'h1F) && (prod_q[9:0] == 10'd0);
  assign a_nan  = (acc[14:10] == 5'h1F) && (acc[9:0] != 10'd0);
  assign b_nan  = (prod_q[14:10] == 5'h1F) && (prod_q[9:0] != 10'd0);
  assign a_key  = a_zero ? 15'd0 : acc[14:0];
  assign b_key  = b_zero ? 15'd0 : prod_q[14:0];

  // ---------------------------------------------------------------------------
  // Alignment. The magnitude key {exp, mantissa} orders the operands
  // directly, so the larger one keeps its place. The smaller one is
  // shifted right by the exponent difference. Any bits shifted out are
  // OR-ed into the sticky position.
  // ---------------------------------------------------------------------------
  logic        swap;
  logic        big_sign;
  logic [14:0] big_key, small_key;
  logic [4:0]  big_exp, small_exp, exp_diff;
  logic [13:0] big_mag, small_mag, small_mask, small_shift, small_al;
  logic        small_sticky;

  assign swap      = (b_key > a_key);
  assign big_sign  = swap ? b_sign : a_sign;
  assign big_key   = swap ? b_key : a_key;
  assign small_key = swap ? a_key : b_key;
  assign big_exp   = big_key[14:10];
  assign small_exp = small_key[14:10];
  assign exp_diff  = big_exp - small_exp;
  assign big_mag   = (big_exp == 5'd0) ? 14'd0 : {1'b1, big_key[9:0], 3'b000};
  assign small_mag = (small_exp == 5'd0) ? 14'd0 : {1'b1, small_key[9:0], 3'b000};

  always_comb begin
    small_mask = ~(14'h3FFF << exp_diff);
    if (exp_diff >= 5'd14) begin
      small_shift  = 14'd0;
      small_sticky = |small_mag;
    end else begin
      small_shift  = small_mag >> exp_diff;
      small_sticky = |(small_mag & small_mask);
    end
    small_al = small_shift | {13'd0, small_sticky};
  end

  // ---------------------------------------------------------------------------
  // Special operands bypass the datapath. A sticky NaN from earlier in the
  // row, a NaN input, or opposite infinities give the canonical NaN. Any
  // other infinity passes through unchanged, without counting as overflow.
  // ---------------------------------------------------------------------------
  logic        spc, spc_nan;
  logic [15:0] spc_data;

  assign spc_nan  = out_nan | a_nan | b_nan | (a_inf & b_inf & (a_sign != b_sign));
  assign spc      = spc_nan | a_inf | b_inf;
  assign spc_data = spc_nan ? 16'h7E00 : (a_inf ? acc : prod_q);

  // ---------------------------------------------------------------------------
  // Magnitude add or subtract. The big operand is never smaller than the
  // aligned small one, so a subtraction cannot go negative.
  // ---------------------------------------------------------------------------
  logic [14:0] add_sum;

  assign add_sum = al_sub ? ({1'b0, al_big} - {1'b0, al_small})
                          : ({1'b0, al_big} + {1'b0, al_small});

  // ---------------------------------------------------------------------------
  // Normalization. A carry costs a 1-bit right shift. Otherwise the leading
  // one is pulled up to the hidden-bit position. The remaining bits are
  // truncated. The exponent is kept signed and wide, so that underflow and
  // overflow both show up as simple range checks.
  // ---------------------------------------------------------------------------
  logic [3:0]        lz;
  logic [13:0]       norm;
  logic signed [6:0] exp_n;
  logic [9:0]        mant;
  logic [15:0]       res;
  logic              res_ovf, res_unf, res_nan;

  always_comb begin
    lz = 4'd0;
    for (int i = 0; i < 14; i++) begin
      if (sum_q[i]) lz = 4'(13 - i);
    end
    norm    = sum_q[13:0] << lz;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res_nan = 1'b0;
    if (sum_q[14]) begin
      exp_n = $signed({2'b00, sum_exp}) + 7'sd1;
      mant  = 10'(sum_q >> 4);
    end else begin
      exp_n = $signed({2'b00, sum_exp}) - $signed({3'b000, lz});
      mant  = 10'(norm >> 3);
    end
    if (spc_q) begin
      res     = spc_data_q;
      res_nan = spc_nan_q;
    end else if (sum_q == 15'd0) begin
      res = 16'h0000;
    end else if (exp_n < 7'sd1) begin
      res     = 16'h0000;
      res_unf = 1'b1;
    end else if (exp_n > 7'sd30) begin
      res     = {sum_sign, 5'h1F, 10'd0};
      res_ovf = 1'b1;
    end else begin
      res = {sum_sign, exp_n[4:0], mant};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM together with the stage registers. The handshake outputs
  // are registered alongside the state, so they always agree with it.
  // Reset wins over clk_en. Reset drops any partial or pending row sum.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      acc           <= 16'h0000;
      out_count     <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_nan       <= 1'b0;
      out_zero      <= 1'b0;
      prod_q        <= 16'h0000;
      last_q        <= 1'b0;
      al_sign       <= 1'b0;
      al_sub        <= 1'b0;
      al_exp        <= 5'd0;
      al_big        <= 14'd0;
      al_small      <= 14'd0;
      spc_q         <= 1'b0;
      spc_nan_q     <= 1'b0;
      spc_data_q    <= 16'h0000;
      sum_q         <= 15'd0;
      sum_sign      <= 1'b0;
      sum_exp       <= 5'd0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            prod_q   <= in_data;
            last_q   <= in_last;
            in_ready <= 1'b0;
            state    <= ALIGN;
            if (out_count != '1) out_count <= out_count + CNT_W'(1);
          end
        end
        ALIGN: begin
          al_sign    <= big_sign;
          al_sub     <= a_sign ^ b_sign;
          al_exp     <= big_exp;
          al_big     <= big_mag;
          al_small   <= small_al;
          spc_q      <= spc;
          spc_nan_q  <= spc_nan;
          spc_data_q <= spc_data;
          state      <= ADD;
        end
        ADD: begin
          sum_q    <= add_sum;
          sum_sign <= al_sign;
          sum_exp  <= al_exp;
          state    <= NORM;
        end
        NORM: begin
          acc           <= res;
          out_overflow  <= out_overflow | res_ovf;
          out_underflow <= out_underflow | res_unf;
          out_nan       <= out_nan | res_nan;
          out_zero      <= (res == 16'h0000);
          if (last_q) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            acc           <= 16'h0000;
            out_count     <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_nan       <= 1'b0;
            out_zero      <= 1'b0;
            out_valid     <= 1'b0;
            in_ready      <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_row_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fp16_row_accumulator
//
// Scoreboard bench for fp16_row_accumulator. Each row's expected sum, count,
// flags and latency are queued when its last product is driven. They are
// popped and compared when the row sum appears. A narrow counter width makes
// saturation reachable.
// -----------------------------------------------------------------------------
module tb_fp16_row_accumulator;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             clk_en;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_overflow;
  logic             out_underflow;
  logic             out_nan;
  logic             out_zero;

  typedef struct {
    logic [15:0]      data;
    logic [CNT_W-1:0] count;
    logic [3:0]       flags;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp16_row_accumulator #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_count     (out_count),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_nan       (out_nan),
    .out_zero      (out_zero)
  );

  // Every comparison in the bench goes through this one task.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Checks the idle state that follows a reset.
  task automatic checkResetState(input string tag);
    checkOutput(tag, {in_ready, out_valid, out_data, out_count,
                      out_overflow, out_underflow, out_nan, out_zero},
                {1'b1, 1'b0, 16'h0000, {CNT_W{1'b0}}, 4'b0000});
  endtask

  // Drives one product and waits for it to be accepted. The inputs are then
  // scrambled, so that the DUT must rely on its captured copy. The task
  // returns at the falling edge of the first cycle after the accept.
  task automatic applyStimulus(input logic [15:0] d, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_last  = 1'($urandom);
    @(negedge clk);
    checkOutput("busy_after_accept", 32'(in_ready), 32'd0);
  endtask

  // Queues the expected row result, then drives the last product.
  task automatic sendLast(input logic [15:0] d, input logic [15:0] expData,
                          input logic [CNT_W-1:0] expCount,
                          input logic [3:0] expFlags, input int expLat);
    exp_t e;
    e.data  = expData;
    e.count = expCount;
    e.flags = expFlags;
    e.lat   = expLat;
    sb.push_back(e);
    applyStimulus(d, 1'b1);
  endtask

  // Optionally stalls clk_en, then waits for the row sum with a bound and
  // compares it with the head of the scoreboard. It can hold out_ready low
  // for a number of cycles first. It returns once the output handshake
  // has completed.
  task automatic collectRow(input int stall, input int hold);
    int   lat;
    exp_t e;
    lat = 1;
    if (stall > 0) begin
      clk_en = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        lat++;
      end
      clk_en = 1'b1;
    end
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid || sb.size() == 0) begin
      checkOutput("out_timeout", 32'd0, 32'd1);
      out_ready = 1'b1;
      return;
    end
    e = sb.pop_front();
    checkOutput("latency", 32'(lat), 32'(e.lat));
    checkOutput("out_data", 32'(out_data), 32'(e.data));
    checkOutput("out_count", 32'(out_count), 32'(e.count));
    checkOutput("flags", 32'({out_overflow, out_underflow, out_nan, out_zero}),
                32'(e.flags));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        checkOutput("hold_state", {out_valid, in_ready, 14'd0, out_data},
                    {1'b1, 1'b0, 14'd0, e.data});
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("after_handshake", 32'({out_valid, in_ready}), 32'd1);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    clk_en    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkResetState("reset_without_enable");
    reset  = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    checkResetState("reset_idle");

    // 1 + 2
    applyStimulus(16'h3C00, 1'b0);
    sendLast(16'h4000, 16'h4200, 3'd2, 4'b0000, 4);
    collectRow(0, 0);

    // 1 + (-1) is exact zero
    applyStimulus(16'h3C00, 1'b0);
    sendLast(16'hBC00, 16'h0000, 3'd2, 4'b0001, 4);
    collectRow(0, 0);

    // max + max overflows
    applyStimulus(16'h7BFF, 1'b0);
    sendLast(16'h7BFF, 16'h7C00, 3'd2, 4'b1000, 4);
    collectRow(0, 0);

    // NaN mid-row sticks
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h7E00, 1'b0);
    sendLast(16'h4000, 16'h7E00, 3'd3, 4'b0010, 4);
    collectRow(0, 0);

    // inf + (-inf)
    applyStimulus(16'h7C00, 1'b0);
    sendLast(16'hFC00, 16'h7E00, 3'd2, 4'b0010, 4);
    collectRow(0, 0);

    // 2^-13 - (2^-14 * (2 - 2^-10)) = 2^-24 flushes to +0
    applyStimulus(16'h0800, 1'b0);
    sendLast(16'h87FF, 16'h0000, 3'd2, 4'b0101, 4);
    collectRow(0, 0);

    // denormal input counts as zero
    applyStimulus(16'h3C00, 1'b0);
    sendLast(16'h0001, 16'h3C00, 3'd2, 4'b0000, 4);
    collectRow(0, 0);

    // inf + finite stays inf with no overflow
    applyStimulus(16'h7C00, 1'b0);
    sendLast(16'h3C00, 16'h7C00, 3'd2, 4'b0000, 4);
    collectRow(0, 0);

    // truncation: the tie would round up to 3E04 under round-to-nearest-even
    applyStimulus(16'h3C03, 1'b0);
    sendLast(16'h3801, 16'h3E03, 3'd2, 4'b0000, 4);
    collectRow(0, 0);

    // nine ones: sum 9.0, count saturates at 7
    for (int i = 0; i < 8; i++) applyStimulus(16'h3C00, 1'b0);
    sendLast(16'h3C00, 16'h4880, 3'd7, 4'b0000, 4);
    collectRow(0, 0);

    // downstream back-pressure for 5 cycles; the next row starts from +0
    out_ready = 1'b0;
    sendLast(16'h4000, 16'h4000, 3'd1, 4'b0000, 4);
    collectRow(0, 5);
    sendLast(16'h3C00, 16'h3C00, 3'd1, 4'b0000, 4);
    collectRow(0, 0);

    // reset during ALIGN of a non-last product
    applyStimulus(16'h4000, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetState("reset_in_align");
    sendLast(16'h3C00, 16'h3C00, 3'd1, 4'b0000, 4);
    collectRow(0, 0);

    // reset while a result is pending in OUT drops it
    out_ready = 1'b0;
    sendLast(16'h4000, 16'h4000, 3'd1, 4'b0000, 4);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pending_before_reset", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    if (sb.size() > 0) void'(sb.pop_front());
    checkResetState("reset_in_out");
    sendLast(16'hBC00, 16'hBC00, 3'd1, 4'b0000, 4);
    collectRow(0, 0);

    // clk_en low for 3 cycles delays out_valid by exactly 3
    applyStimulus(16'h3C00, 1'b0);
    sendLast(16'h4000, 16'h4200, 3'd2, 4'b0000, 7);
    collectRow(3, 0);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_row_accumulator.md
FP16_ROW_ACCUMULATOR -- requirements
Module: fp16_row_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the per-row product counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port clk_en, input, 1: when low, all registers hold and no handshake completes.
REQ-005 SHALL have port in_valid, input, 1: product on in_data is valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept a product this cycle.
REQ-007 SHALL have port in_data, input, 16: FP16 product from the multiplier (1 sign, 5 exponent, 10 mantissa bits, bias 15).
REQ-008 SHALL have port in_last, input, 1: qualified by in_valid; the product is the last of the current sparse row.
REQ-009 SHALL have port out_valid, output, 1: row sum is valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the row sum.
REQ-011 SHALL have port out_data, output, 16: FP16 row sum.
REQ-012 SHALL have port out_count, output, CNT_W: number of products accumulated into out_data; saturates at all-ones.
REQ-013 SHALL have ports out_overflow, out_underflow, out_nan, out_zero, output, 1 each: sticky row flags; out_zero reflects out_data only.

Function
REQ-014 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, OUT.
REQ-015 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-016 An accept (in_valid & in_ready & clk_en) SHALL move IDLE->ALIGN, then ALIGN->ADD->NORM, one state per enabled cycle.
REQ-017 After NORM, the FSM SHALL go to OUT if the accepted product had in_last=1; otherwise it SHALL return to IDLE.
REQ-018 Accept-to-ready latency SHALL be 4 enabled cycles; accept-to-out_valid latency for a last product SHALL be 4 enabled cycles.
REQ-019 In OUT, out_valid SHALL be 1 and out_data and all out_* SHALL be stable until the cycle in which out_ready & clk_en is 1.
REQ-020 On that out handshake, the FSM SHALL return to IDLE and clear the accumulator to +0, the counter to 0, and the sticky flags to 0.
REQ-021 The accumulator SHALL start each row at +0; each accepted product SHALL be added as acc = acc + in_data.
REQ-022 ALIGN SHALL shift the smaller-magnitude operand right by the exponent difference, keeping guard, round and sticky bits (sticky = OR of all shifted-out bits).
REQ-023 ADD SHALL add or subtract the 14-bit aligned magnitudes by sign (hidden bit, 10 mantissa bits, G, R, S) plus 1 carry bit.
REQ-024 NORM SHALL normalize with a leading-zero shift or a 1-bit right shift on carry, then truncate (round toward zero).
REQ-025 Inputs with exponent 0 (zero or denormal) SHALL be treated as a zero of the same sign.
REQ-026 A result whose normalized exponent is below 1 SHALL be flushed to +0 and SHALL set out_underflow.
REQ-027 A result whose exponent exceeds 30 SHALL become signed infinity (7C00/FC00) and SHALL set out_overflow.
REQ-028 An exact-zero sum SHALL be +0 (16'h0000).
REQ-029 Any NaN input SHALL force out_data to 16'h7E00 and set out_nan, as SHALL inf + (-inf); the NaN persists for the rest of the row.
REQ-030 inf plus a finite value SHALL give that inf; an inf input SHALL NOT set out_overflow.
REQ-031 out_count SHALL increment once per accepted product and saturate at 2^CNT_W-1.
REQ-032 in_data and in_last SHALL be captured at accept; later input changes SHALL NOT affect the operation in flight.

Reset
REQ-033 When reset=1 at a clock edge, regardless of clk_en, the block SHALL go to IDLE and drive in_ready=1, out_valid=0, out_data=0000, out_count=0 and all flags 0; the accumulator SHALL be +0.
REQ-034 Reset asserted mid-row or in OUT SHALL discard the partial or pending sum without emitting it.

Verification
REQ-035 Accepting 3C00 then 4000 (last) SHALL give out_data=4200, out_count=2, flags 0; out_valid SHALL rise 4 cycles after the second accept.
REQ-036 Accepting 3C00 then BC00 (last) SHALL give out_data=0000, out_zero=1.
REQ-037 Accepting 7BFF then 7BFF (last) SHALL give out_data=7C00, out_overflow=1.
REQ-038 Accepting 3C00, 7E00, 4000 (last) SHALL give out_data=7E00, out_nan=1, out_count=3.
REQ-039 Holding out_ready=0 for 5 cycles in OUT SHALL keep out_valid=1, out_data stable and in_ready=0; out_ready=1 SHALL then return the FSM to IDLE, and the next row SHALL start from +0.
REQ-040 Asserting reset during ALIGN of a non-last product, then sending 3C00 (last), SHALL give out_data=3C00, out_count=1; holding clk_en=0 for 3 cycles mid-operation SHALL delay out_valid by exactly 3 cycles.
